// File: rtl/byte_deint_ctrl.sv
// Block-interleaver memory client: writes a ROWS x COLS block row-major, reads it back column-major.
// Optional feature macro: BYTE_DEINT_DROP_CNT_EN (counts input bytes offered while not in WR).
module byte_deint_ctrl #(
  parameter int ROWS = 144,
  parameter int COLS = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [7:0]  out_data,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        out_sof,
  output logic        out_eob,
  output logic [16:0] mem_ad,
  output logic [7:0]  mem_di,
  output logic        mem_en,
  output logic        mem_wr,
  input  logic [7:0]  mem_do,
  input  logic        mdo_en,
  output logic [15:0] drop_cnt
);

  localparam int          NBYTES    = ROWS * COLS;
  localparam logic [16:0] LAST_ADDR = 17'(NBYTES - 1);
  localparam logic [16:0] ROW_LAST  = 17'(ROWS - 1);
  localparam logic [16:0] COL_LAST  = 17'(COLS - 1);
  localparam logic [16:0] COL_STEP  = 17'(COLS);

  typedef enum logic [1:0] {WR, RD, DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [16:0] r_wr_cnt;
  logic [16:0] r_rd_addr;
  logic [16:0] r_row;
  logic [16:0] r_col;
  logic        r_inflight;
  logic        r_tag_sof;
  logic        r_tag_eob;
  logic [7:0]  r_fd [2];
  logic        r_fs [2];
  logic        r_fe [2];
  logic        r_wp;
  logic        r_rp;
  logic [1:0]  r_occ;

  logic        w_in_rdy;
  logic        w_out_vld;
  logic        w_pop;
  logic        w_rd_issue;
  logic        w_wr_accept;
  logic [2:0]  w_occ_sum;
  logic [2:0]  w_occ_limit;

  assign w_in_rdy    = (r_state == WR);
  assign w_out_vld   = (r_occ != 2'd0);
  assign w_pop       = w_out_vld & out_rdy;
  assign w_wr_accept = w_in_rdy & in_vld;
  // occ + inflight - pop < 2, rearranged to stay unsigned
  assign w_occ_sum   = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_occ_limit = 3'd2 + {2'b00, w_pop};
  assign w_rd_issue  = (r_state == RD) && (w_occ_sum < w_occ_limit);

  assign in_rdy   = w_in_rdy;
  assign out_vld  = w_out_vld;
  assign out_data = w_out_vld ? r_fd[r_rp] : 8'd0;
  assign out_sof  = w_out_vld & r_fs[r_rp];
  assign out_eob  = w_out_vld & r_fe[r_rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WR;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_ad       = 17'd0;
    mem_di       = 8'd0;
    case (r_state)
      WR: begin
        if (in_vld) begin
          mem_en = 1'b1;
          mem_wr = 1'b1;
          mem_ad = r_wr_cnt;
          mem_di = in_data;
          if (r_wr_cnt == LAST_ADDR) w_state_next = RD;
        end
      end
      RD: begin
        if (w_rd_issue) begin
          mem_en = 1'b1;
          mem_ad = r_rd_addr;
          if ((r_row == ROW_LAST) && (r_col == COL_LAST)) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_occ == 2'd0) && !r_inflight) w_state_next = WR;
      end
      default: w_state_next = WR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_cnt <= 17'd0;
    end else if (w_wr_accept) begin
      r_wr_cnt <= (r_wr_cnt == LAST_ADDR) ? 17'd0 : r_wr_cnt + 17'd1;
    end
  end

  // Column-major walk; the final read wraps all counters back to address 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr <= 17'd0;
      r_row     <= 17'd0;
      r_col     <= 17'd0;
      r_tag_sof <= 1'b0;
      r_tag_eob <= 1'b0;
    end else if (w_rd_issue) begin
      r_tag_sof <= (r_rd_addr == 17'd0);
      r_tag_eob <= (r_rd_addr == LAST_ADDR);
      if (r_row < ROW_LAST) begin
        r_row     <= r_row + 17'd1;
        r_rd_addr <= r_rd_addr + COL_STEP;
      end else begin
        r_row <= 17'd0;
        if (r_col == COL_LAST) begin
          r_col     <= 17'd0;
          r_rd_addr <= 17'd0;
        end else begin
          r_col     <= r_col + 17'd1;
          r_rd_addr <= r_col + 17'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_inflight <= 1'b0;
    else if (w_rd_issue) r_inflight <= 1'b1;
    else if (mdo_en)     r_inflight <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fd[i] <= 8'd0;
        r_fs[i] <= 1'b0;
        r_fe[i] <= 1'b0;
      end
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (mdo_en) begin
        r_fd[r_wp] <= mem_do;
        r_fs[r_wp] <= r_tag_sof;
        r_fe[r_wp] <= r_tag_eob;
        r_wp       <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({mdo_en, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef BYTE_DEINT_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 16'd0;
    end else if (in_vld && !w_in_rdy && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_byte_deint_ctrl.sv
// Randomized bench for byte_deint_ctrl: memory model, column-major expectation queue and per-cycle checks.
module tb_byte_deint_ctrl;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eob;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        out_sof;
  logic        out_eob;
  logic [16:0] mem_ad;
  logic [7:0]  mem_di;
  logic        mem_en;
  logic        mem_wr;
  logic [7:0]  mem_do;
  logic        mdo_en;
  logic [15:0] drop_cnt;

  byte_deint_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_sof(out_sof), .out_eob(out_eob),
    .mem_ad(mem_ad), .mem_di(mem_di), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_do(mem_do), .mdo_en(mdo_en), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: one-cycle registered read
  logic [7:0] mem_arr [N];
  always @(posedge clk) begin
    mdo_en <= 1'b0;
    if (!reset_n) begin
      mdo_en <= 1'b0;
    end else if (mem_en && (int'(mem_ad) < N)) begin
      if (mem_wr) mem_arr[int'(mem_ad)] <= mem_di;
      else begin
        mdo_en <= 1'b1;
        mem_do <= mem_arr[int'(mem_ad)];
      end
    end
  end

  // Behavioural model state
  logic [7:0] blk [N];
  exp_t       exp_q [$];
  int         rd_q [$];
  int         wr_idx = 0;
  int         rd_seen = 0;
  int         outstanding = 0;
  int         drop_model = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  int         first_rd_cyc = 0;
  int         out_cnt = 0;
  logic       expect_drop = 1'b0;
  int         rdy_mode = 0;
  logic       rec_first = 1'b0;
  logic [7:0] obs_data [N];
  int         obs_rd [N];
  int         obs_cnt = 0;
  int         obs_rd_cnt = 0;
  int         obs_sof_idx = -1;
  int         obs_eob_idx = -1;

  // Block complete: the output order is column-major over the row-major stored block
  task automatic build_expect();
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        int   a;
        exp_t e;
        a     = r * COLS + c;
        e.d   = blk[a];
        e.sof = (a == 0);
        e.eob = (a == N - 1);
        exp_q.push_back(e);
        rd_q.push_back(a);
      end
    end
    rd_seen = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_in_rdy", 32'(in_rdy), 32'd1);
      chk("rst_out", {28'd0, out_vld, out_sof, out_eob, 1'b0}, 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_mem", {6'd0, mem_en, mem_wr, mem_ad, mem_di}, 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      wr_idx = 0;
      exp_q.delete();
      rd_q.delete();
      outstanding = 0;
      drop_model = 0;
    end else begin
      if (in_vld && expect_drop) begin
        chk("drop_in_rdy", 32'(in_rdy), 32'd0);
        chk("drop_no_write", 32'(mem_en & mem_wr), 32'd0);
        if (drop_model < 65535) drop_model++;
      end else if (in_vld) begin
        chk("wr_in_rdy", 32'(in_rdy), 32'd1);
        chk("wr_en", {30'd0, mem_en, mem_wr}, 32'd3);
        chk("wr_addr", 32'(mem_ad), 32'(wr_idx));
        chk("wr_data", 32'(mem_di), 32'(in_data));
        chk("wr_before_eob_accepted", 32'(exp_q.size()), 32'd0);
        blk[wr_idx] = in_data;
        last_wr_cyc = cyc;
        wr_idx++;
        if (wr_idx == N) begin
          build_expect();
          wr_idx = 0;
        end
      end
      if (mem_en && !mem_wr) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 32'(mem_ad), 32'hFFFFFFFF);
        end else begin
          int a;
          a = rd_q.pop_front();
          chk("rd_addr", 32'(mem_ad), 32'(a));
          if (rec_first && obs_rd_cnt < N) begin
            obs_rd[obs_rd_cnt] = int'(mem_ad);
            obs_rd_cnt++;
          end
          if (rd_seen == 0) begin
            first_rd_cyc = cyc;
            chk("first_rd_latency", 32'(cyc - last_wr_cyc), 32'd1);
          end
          rd_seen++;
          if (rd_seen == N && rdy_mode == 0)
            chk("rd_rate", 32'(cyc - first_rd_cyc), 32'(N - 1));
        end
        outstanding++;
      end
      if (!mem_en) chk("mem_idle_zero", {6'd0, 1'b0, mem_wr, mem_ad, mem_di}, 32'd0);
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'(out_data), 32'hFFFFFFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_sof", 32'(out_sof), 32'(exp_q[0].sof));
          chk("out_eob", 32'(out_eob), 32'(exp_q[0].eob));
          if (out_rdy) begin
            void'(exp_q.pop_front());
            outstanding--;
            $display("out #%0d data=%0d sof=%0b eob=%0b", out_cnt, out_data, out_sof, out_eob);
            out_cnt++;
            if (rec_first && obs_cnt < N) begin
              obs_data[obs_cnt] = out_data;
              if (out_sof) obs_sof_idx = obs_cnt;
              if (out_eob) obs_eob_idx = obs_cnt;
              obs_cnt++;
            end
          end
        end
      end
      chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
`ifdef BYTE_DEINT_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_model));
`else
      chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    end
  end

  int pcnt = 0;
  always @(posedge clk) begin
    #1;
    pcnt++;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ((pcnt % 4) == 0) || ((pcnt % 4) == 3);
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!in_rdy && k < 300) begin
      tick();
      k++;
    end
    if (!in_rdy) chk("in_rdy_timeout", 32'(in_rdy), 32'd1);
  endtask

  task automatic send_block(input logic [7:0] base, input bit seq, input bit gaps, input int nbytes);
    wait_rdy();
    for (int i = 0; i < nbytes; i++) begin
      while (gaps && ($urandom_range(0, 2) == 0)) begin
        in_vld = 1'b0;
        tick();
      end
      in_vld  = 1'b1;
      in_data = seq ? base + 8'(i) : 8'($urandom);
      tick();
    end
    in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && k < 500) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(exp_q.size() + rd_q.size()), 32'd0);
  endtask

  int lit [N] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

  initial begin
    reset_n = 1'b0;
    in_vld  = 1'b0;
    in_data = 8'd0;
    out_rdy = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;

    // Basic block 0..11 with steady ready; capture to pin the model against literals
    rdy_mode  = 0;
    rec_first = 1'b1;
    send_block(8'd0, 1'b1, 1'b0, N);
    wait_drain();
    rec_first = 1'b0;
    chk("lit_out_count", 32'(obs_cnt), 32'(N));
    chk("lit_rd_count", 32'(obs_rd_cnt), 32'(N));
    for (int k = 0; k < N; k++) begin
      chk("lit_out_data", 32'(obs_data[k]), 32'(lit[k]));
      chk("lit_rd_addr", 32'(obs_rd[k]), 32'(lit[k]));
    end
    chk("lit_sof_idx", 32'(obs_sof_idx), 32'd0);
    chk("lit_eob_idx", 32'(obs_eob_idx), 32'(N - 1));

    // Ready toggling 1,0,0,1
    rdy_mode = 1;
    send_block(8'd0, 1'b1, 1'b0, N);
    wait_drain();

    // Bytes offered during RD are dropped
    rdy_mode = 0;
    send_block(8'd0, 1'b0, 1'b0, N);
    expect_drop = 1'b1;
    in_vld = 1'b1;
    repeat (5) tick();
    in_vld = 1'b0;
    expect_drop = 1'b0;
    wait_drain();
`ifdef BYTE_DEINT_DROP_CNT_EN
    chk("drop_cnt_total", 32'(drop_cnt), 32'd5);
`else
    chk("drop_cnt_total", 32'(drop_cnt), 32'd0);
`endif

    // Back-to-back blocks under random backpressure
    rdy_mode = 2;
    send_block(8'd0, 1'b1, 1'b0, N);
    send_block(8'd100, 1'b1, 1'b0, N);
    wait_drain();

    // Random data, random input gaps, random ready
    for (int b = 0; b < 4; b++) begin
      send_block(8'd0, 1'b0, 1'b1, N);
      wait_drain();
    end

    // Reset in the middle of a block, then a full block from address 0
    rdy_mode = 0;
    send_block(8'd0, 1'b1, 1'b0, 6);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    send_block(8'd0, 1'b1, 1'b0, N);
    wait_drain();
    chk("post_reset_drop_cnt", 32'(drop_cnt), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule
